// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared AXI response codes and the SRAM slave state encoding
package cpu_types_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_W_COLLECT, S_DELAY, S_RRESP, S_BRESP} sram_state_e;
endpackage

// File: rtl/AXI4_Lite.sv
// AXI4_Lite: 32-bit AXI4-Lite channel bundle with master and slave views
interface AXI4_Lite;
  logic [31:0] awaddr;
  logic awvalid;
  logic awready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wvalid;
  logic wready;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  logic [31:0] araddr;
  logic arvalid;
  logic arready;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rvalid;
  logic rready;
  modport slave (
    input awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/sram_delay_lfsr.sv
// sram_delay_lfsr: randomised response delay, LATENCY plus the low nibble of an 8-bit LFSR
module sram_delay_lfsr #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic now,
  output logic done
);
  logic [7:0] lfsr;
  logic [7:0] cnt;
  logic [7:0] tgt;
  logic [7:0] tgt_q;
  assign tgt = 8'(LATENCY) + {4'd0, lfsr[3:0]};
  assign now = tgt == 8'd0;
  assign done = cnt + 8'd1 == tgt_q;
  // target is captured from the pre-advance LFSR value so it stays fixed for the whole delay
  always_ff @(posedge clk)
    if (rst) begin
      lfsr <= 8'hA5;
      cnt <= 8'd0;
      tgt_q <= 8'd0;
    end else if (load) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      tgt_q <= tgt;
      cnt <= 8'd0;
    end else if (run) begin
      cnt <= cnt + 8'd1;
    end
endmodule

// File: rtl/axi_lite_sram.sv
// axi_lite_sram: single-outstanding AXI4-Lite word SRAM with byte strobes and programmable latency
module axi_lite_sram import cpu_types_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY = 1,
  parameter string INIT_FILE = ""
) (
  input logic clk,
  input logic rst,
  AXI4_Lite.slave slave_if
);
  localparam int IW = $clog2(DEPTH_WORDS);
  sram_state_e state, state_d;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q;
  logic [3:0] wstrb_q, wstrb_d;
  logic [29:0] widx;
  logic [IW-1:0] idx;
  logic [1:0] rresp_q, bresp_q;
  logic rd_q, rd_d, have_aw, ar_hs, aw_hs, w_hs, go, fire, now, done, hit;
  assign slave_if.arready = state == S_IDLE;
  assign slave_if.awready = state == S_IDLE ? !slave_if.arvalid : state == S_W_COLLECT && !have_aw;
  assign slave_if.wready = state == S_IDLE ? !slave_if.arvalid : state == S_W_COLLECT && have_aw;
  assign slave_if.rvalid = state == S_RRESP;
  assign slave_if.bvalid = state == S_BRESP;
  assign slave_if.rdata = rdata_q;
  assign slave_if.rresp = rresp_q;
  assign slave_if.bresp = bresp_q;
  assign ar_hs = slave_if.arvalid && slave_if.arready;
  assign aw_hs = slave_if.awvalid && slave_if.awready;
  assign w_hs = slave_if.wvalid && slave_if.wready;
  assign go = state == S_IDLE ? ar_hs || (aw_hs && w_hs) : state == S_W_COLLECT && (aw_hs || w_hs);
  assign rd_d = state == S_IDLE ? ar_hs : rd_q;
  assign addr_d = ar_hs ? slave_if.araddr : aw_hs ? slave_if.awaddr : addr_q;
  assign wdata_d = w_hs ? slave_if.wdata : wdata_q;
  assign wstrb_d = w_hs ? slave_if.wstrb : wstrb_q;
  assign fire = (go && now) || (state == S_DELAY && done);
  assign widx = 30'((addr_d - BASE_ADDR) >> 2);
  assign hit = addr_d >= BASE_ADDR && widx < 30'(DEPTH_WORDS);
  assign idx = widx[IW-1:0];
`ifdef SRAM_RAND_DELAY_EN
  sram_delay_lfsr #(.LATENCY(LATENCY)) u_delay (
    .clk(clk),
    .rst(rst),
    .load(go),
    .run(state == S_DELAY),
    .now(now),
    .done(done)
  );
`else
  logic [7:0] cnt;
  assign now = LATENCY == 0;
  assign done = cnt + 8'd1 == 8'(LATENCY);
  always_ff @(posedge clk)
    cnt <= rst || go ? 8'd0 : state == S_DELAY ? cnt + 8'd1 : cnt;
`endif
  always_comb begin
    state_d = fire ? (rd_d ? S_RRESP : S_BRESP)
            : go ? S_DELAY
            : state == S_IDLE && (aw_hs || w_hs) ? S_W_COLLECT
            : (state == S_RRESP && slave_if.rready) || (state == S_BRESP && slave_if.bready) ? S_IDLE
            : state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      have_aw <= 1'b0;
      rdata_q <= 32'd0;
      rresp_q <= RESP_OKAY;
      bresp_q <= RESP_OKAY;
    end else begin
      state <= state_d;
      if (state == S_IDLE) have_aw <= aw_hs;
      if (fire && rd_d) begin
        rdata_q <= hit ? mem[idx] : 32'd0;
        rresp_q <= hit ? RESP_OKAY : RESP_DECERR;
      end
      if (fire && !rd_d) bresp_q <= hit ? RESP_OKAY : RESP_DECERR;
    end
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
    rd_q <= rd_d;
  end
  always_ff @(posedge clk)
    if (!rst && fire && !rd_d && hit)
      for (int b = 0; b < 4; b++)
        if (wstrb_d[b]) mem[idx][8*b +: 8] <= wdata_d[8*b +: 8];
endmodule
